regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (WriteRegister, WriteData, RegWrite) between NUM_REQ requesters, e.g. ALU writeback and load writeback.
- Round-robin arbitration, req/grant handshake, registered write-port outputs.
- Built-in clear sequencer: on command, writes zero to registers 1..31, one per cycle.
- Sits directly in front of the register file's write decoders.

---
 rtl/regfile_write_arbiter_if.sv | 27 ++
 rtl/regfile_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between the requesters, the clear command source and the
// register-file write arbiter. The arbiter sits on the slave side.
interface regfile_write_arbiter_if #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_REQ     = 2
);
  logic [NUM_REQ-1:0]             req;
  logic [5*NUM_REQ-1:0]           req_addr;
  logic [WORD_LENGTH*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             grant;
  logic                           clear_req;
  logic                           busy;
  logic                           clear_done;
  logic [4:0]                     WriteRegister;
  logic [WORD_LENGTH-1:0]         WriteData;
  logic                           RegWrite;

  modport master (
    output req, req_addr, req_data, clear_req,
    input  grant, busy, clear_done, WriteRegister, WriteData, RegWrite
  );

  modport slave (
    input  req, req_addr, req_data, clear_req,
    output grant, busy, clear_done, WriteRegister, WriteData, RegWrite
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a built-in
// sequencer that zeroes registers 1..31 on command.
module regfile_write_arbiter #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_REQ     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int         PTR_W    = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [4:0] LAST_REG = 5'd31;
  localparam logic [4:0] FIRST_CLR_REG = 5'd1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [4:0]             clr_cnt_q, clr_cnt_d;
  logic [4:0]             wr_addr_q, wr_addr_d;
  logic [WORD_LENGTH-1:0] wr_data_q, wr_data_d;
  logic                   reg_write_q, reg_write_d;
  logic                   busy_q, busy_d;
  logic                   clear_done_q, clear_done_d;

  logic                   arb_en;
  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [4:0]             win_addr;
  logic [WORD_LENGTH-1:0] win_data;
  logic [NUM_REQ-1:0]     grant;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Cyclic search from rr_ptr: first pass covers rr_ptr..NUM_REQ-1, second wraps to 0..rr_ptr-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && bus.req[i] && (i >= int'(rr_ptr_q))) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && bus.req[i] && (i < int'(rr_ptr_q))) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_addr = bus.req_addr[5*i +: 5];
        win_data = bus.req_data[WORD_LENGTH*i +: WORD_LENGTH];
      end
    end
  end

  // A clear command steals the cycle from every requester, and nothing is granted in reset.
  assign arb_en = !reset && (state_q == IDLE) && !bus.clear_req;

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = arb_en && win_found && (win_idx == PTR_W'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    clr_cnt_d    = clr_cnt_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    reg_write_d  = 1'b0;
    busy_d       = busy_q;
    clear_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = FIRST_CLR_REG;
          busy_d    = 1'b1;
        end else if (win_found) begin
          // Register 0 is hardwired: the request is consumed but never reaches the decoders.
          wr_addr_d   = win_addr;
          wr_data_d   = win_data;
          reg_write_d = (win_addr != 5'd0);
          rr_ptr_d    = ptr_inc(win_idx);
        end
      end
      CLEAR: begin
        wr_addr_d   = clr_cnt_q;
        wr_data_d   = '0;
        reg_write_d = 1'b1;
        if (clr_cnt_q == LAST_REG) begin
          state_d      = IDLE;
          clr_cnt_d    = FIRST_CLR_REG;
          busy_d       = 1'b0;
          clear_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-port register stage: outputs go straight to the register-file decoders.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      clr_cnt_q    <= FIRST_CLR_REG;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      reg_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      clr_cnt_q    <= clr_cnt_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      reg_write_q  <= reg_write_d;
      busy_q       <= busy_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign bus.grant         = grant;
  assign bus.busy          = busy_q;
  assign bus.clear_done    = clear_done_q;
  assign bus.WriteRegister = wr_addr_q;
  assign bus.WriteData     = wr_data_q;
  assign bus.RegWrite      = reg_write_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scenario bench for regfile_write_arbiter: expected writes are queued when a
// transfer is predicted and matched against every RegWrite pulse.
module tb_regfile_write_arbiter;
  localparam int NR = 2;
  localparam int WL = 32;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   tb_ptr;
  wr_t  exp_q[$];
  wr_t  mon_e;

  regfile_write_arbiter_if #(.WORD_LENGTH(WL), .NUM_REQ(NR)) bus ();

  regfile_write_arbiter #(.WORD_LENGTH(WL), .NUM_REQ(NR)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: every issued write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.RegWrite === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got reg=%0d data=%h, expected no write", bus.WriteRegister, bus.WriteData);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.WriteRegister !== mon_e.a || bus.WriteData !== mon_e.d) begin
          n_err++;
          $display("FAIL wr_data: got reg=%0d data=%h, expected reg=%0d data=%h",
                   bus.WriteRegister, bus.WriteData, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_addr[5*i +: 5]  = a;
    bus.req_data[WL*i +: WL] = d;
  endtask

  function automatic logic [NR-1:0] model_grant(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return NR'(1) << ((p + k) % NR);
    end
    return '0;
  endfunction

  task automatic model_commit(input logic [NR-1:0] g);
    wr_t w;
    for (int i = 0; i < NR; i++) begin
      if (g[i]) begin
        w.a = bus.req_addr[5*i +: 5];
        w.d = bus.req_data[WL*i +: WL];
        if (w.a != 5'd0) exp_q.push_back(w);
        tb_ptr = (i + 1) % NR;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = 2'b11;
    repeat (2) tick();
    n_cmp++;
    if (bus.grant !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
    n_cmp++;
    if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd0 || bus.WriteData !== 32'd0 ||
        bus.busy !== 1'b0 || bus.clear_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got rw=%b wr=%0d wd=%h busy=%b done=%b want all 0",
               bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.busy, bus.clear_done);
    end
    reset = 1'b0;
    bus.req = 2'b00;
    tb_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (bus.grant !== 2'b00) begin n_err++; $display("FAIL idle_grant: got %b want 00", bus.grant); end
      tick();
      n_cmp++;
      if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_outputs: got rw=%b wr=%0d busy=%b want 0/0/0", bus.RegWrite, bus.WriteRegister, bus.busy);
      end
    end
  endtask

  task automatic test_single();
    set_req(0, 5'd5, 32'hDEADBEEF);
    bus.req = 2'b01;
    #1;
    n_cmp++;
    if (bus.grant !== 2'b01) begin n_err++; $display("FAIL single_grant: got %b want 01", bus.grant); end
    model_commit(2'b01);
    tick();
    bus.req = 2'b00;
    n_cmp++;
    if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd5 || bus.WriteData !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL single_write: got rw=%b wr=%0d wd=%h want 1/5/deadbeef", bus.RegWrite, bus.WriteRegister, bus.WriteData);
    end
    tick();
    n_cmp++;
    if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd5) begin
      n_err++;
      $display("FAIL single_after: got rw=%b wr=%0d want 0/5", bus.RegWrite, bus.WriteRegister);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] g, g_prev;
    g_prev = '0;
    set_req(0, 5'd3, 32'h33333333);
    set_req(1, 5'd7, 32'h77777777);
    bus.req = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      g = model_grant(bus.req, tb_ptr);
      n_cmp++;
      if (bus.grant !== g || g === g_prev) begin
        n_err++;
        $display("FAIL rr_grant: cycle %0d got %b want %b (previous %b)", c, bus.grant, g, g_prev);
      end
      model_commit(g);
      g_prev = g;
      tick();
      n_cmp++;
      if (bus.RegWrite !== 1'b1) begin n_err++; $display("FAIL rr_regwrite: cycle %0d got %b want 1", c, bus.RegWrite); end
    end
    bus.req = 2'b00;
    tick();
    n_cmp++;
    if (bus.RegWrite !== 1'b0) begin n_err++; $display("FAIL rr_end: got %b want 0", bus.RegWrite); end
  endtask

  task automatic test_reg0();
    set_req(1, 5'd0, 32'h00000BAD);
    bus.req = 2'b10;
    #1;
    n_cmp++;
    if (bus.grant !== 2'b10) begin n_err++; $display("FAIL reg0_grant: got %b want 10", bus.grant); end
    model_commit(2'b10);
    tick();
    bus.req = 2'b11;
    n_cmp++;
    if (bus.RegWrite !== 1'b0) begin n_err++; $display("FAIL reg0_regwrite: got %b want 0", bus.RegWrite); end
    #1;
    n_cmp++;
    if (bus.grant !== 2'b01) begin n_err++; $display("FAIL reg0_rr_next: got %b want 01", bus.grant); end
    model_commit(2'b01);
    tick();
    bus.req = 2'b00;
    n_cmp++;
    if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd3) begin
      n_err++;
      $display("FAIL reg0_follow: got rw=%b wr=%0d want 1/3", bus.RegWrite, bus.WriteRegister);
    end
    tick();
  endtask

  task automatic test_clear_collision();
    wr_t w;
    logic [NR-1:0] g;
    set_req(0, 5'd12, 32'hC0FFEE00);
    bus.req = 2'b01;
    bus.clear_req = 1'b1;
    #1;
    n_cmp++;
    if (bus.grant !== 2'b00) begin n_err++; $display("FAIL clr_collide_grant: got %b want 00", bus.grant); end
    tick();
    bus.clear_req = 1'b0;
    n_cmp++;
    if (bus.RegWrite !== 1'b0) begin n_err++; $display("FAIL clr_start_rw: got %b want 0", bus.RegWrite); end
    for (int n = 1; n <= 31; n++) begin
      bus.clear_req = (n == 15);
      #1;
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.grant !== 2'b00 || bus.clear_done !== 1'b0) begin
        n_err++;
        $display("FAIL clr_busy: step %0d got busy=%b grant=%b done=%b want 1/00/0", n, bus.busy, bus.grant, bus.clear_done);
      end
      w.a = 5'(n);
      w.d = 32'd0;
      exp_q.push_back(w);
      tick();
      n_cmp++;
      if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'(n) || bus.WriteData !== 32'd0) begin
        n_err++;
        $display("FAIL clr_write: step %0d got rw=%b wr=%0d wd=%h want 1/%0d/0", n, bus.RegWrite, bus.WriteRegister, bus.WriteData, n);
      end
    end
    bus.clear_req = 1'b0;
    #1;
    g = model_grant(bus.req, tb_ptr);
    n_cmp++;
    if (bus.clear_done !== 1'b1 || bus.busy !== 1'b0 || bus.grant !== 2'b01 || g !== 2'b01) begin
      n_err++;
      $display("FAIL clr_done: got done=%b busy=%b grant=%b want 1/0/01", bus.clear_done, bus.busy, bus.grant);
    end
    model_commit(g);
    tick();
    bus.req = 2'b00;
    n_cmp++;
    if (bus.clear_done !== 1'b0 || bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd12) begin
      n_err++;
      $display("FAIL clr_after: got done=%b rw=%b wr=%0d want 0/1/12", bus.clear_done, bus.RegWrite, bus.WriteRegister);
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    wr_t w;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      w.a = 5'(n);
      w.d = 32'd0;
      exp_q.push_back(w);
      tick();
    end
    n_cmp++;
    if (bus.WriteRegister !== 5'd9 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_clr_pre: got wr=%0d busy=%b want 9/1", bus.WriteRegister, bus.busy);
    end
    reset = 1'b1;
    set_req(0, 5'd4, 32'h44444444);
    set_req(1, 5'd6, 32'h66666666);
    bus.req = 2'b11;
    #1;
    n_cmp++;
    if (bus.grant !== 2'b00) begin n_err++; $display("FAIL rst_clr_grant: got %b want 00", bus.grant); end
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd0 || bus.clear_done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_clr_vals: got busy=%b rw=%b wr=%0d done=%b want 0/0/0/0", bus.busy, bus.RegWrite, bus.WriteRegister, bus.clear_done);
    end
    reset = 1'b0;
    bus.req = 2'b00;
    tb_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (bus.clear_done !== 1'b0 || bus.RegWrite !== 1'b0) begin
        n_err++;
        $display("FAIL rst_clr_quiet: got done=%b rw=%b want 0/0", bus.clear_done, bus.RegWrite);
      end
    end
    bus.req = 2'b11;
    #1;
    n_cmp++;
    if (bus.grant !== 2'b01) begin n_err++; $display("FAIL rst_ptr: got %b want 01", bus.grant); end
    model_commit(2'b01);
    tick();
    bus.req = 2'b00;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    for (int n = 1; n <= 31; n++) begin
      w.a = 5'(n);
      w.d = 32'd0;
      exp_q.push_back(w);
      tick();
      n_cmp++;
      if (bus.WriteRegister !== 5'(n)) begin
        n_err++;
        $display("FAIL restart_write: step %0d got wr=%0d want %0d", n, bus.WriteRegister, n);
      end
    end
    n_cmp++;
    if (bus.clear_done !== 1'b1) begin n_err++; $display("FAIL restart_done: got %b want 1", bus.clear_done); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] g, g_prev;
    g_prev = '0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!(bus.req[i] && !g_prev[i])) begin
          bus.req[i] = 1'($urandom_range(0, 1));
          set_req(i, 5'($urandom_range(0, 31)), $urandom);
        end
      end
      #1;
      g = model_grant(bus.req, tb_ptr);
      n_cmp++;
      if (bus.grant !== g) begin n_err++; $display("FAIL b2b_grant: cycle %0d got %b want %b", c, bus.grant, g); end
      model_commit(g);
      g_prev = g;
      tick();
    end
    bus.req = 2'b00;
    repeat (2) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    n_cmp = 0;
    n_err = 0;
    tb_ptr = 0;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.clear_req = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_reg0();
    test_clear_collision();
    test_reset_mid_clear();
    test_back_to_back();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d expected writes never issued, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
